// File: rtl/pipe_tag_chain.sv
// pipe_tag_chain: DEPTH-stage result/tag/wen/ctrl pipeline with stall, flush and two-operand tag forwarding; PIPE_ZERO_TAG_EN makes tag 0 a hardwired-zero register
module pipe_tag_chain #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int CTRL_W = 2,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  src_a,
  input  logic [TAG_W-1:0]  src_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wen,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [3:0]        occ
);
  logic [DEPTH-1:0]  vld, wen_r, live;
  logic [DATA_W-1:0] dat [DEPTH];
  logic [TAG_W-1:0]  tg  [DEPTH];
  logic [CTRL_W-1:0] ct  [DEPTH];

  assign in_ready = !stall;

  for (genvar g = 0; g < DEPTH; g++) begin : g_live
`ifdef PIPE_ZERO_TAG_EN
    assign live[g] = vld[g] & wen_r[g] & (tg[g] != '0);
`else
    assign live[g] = vld[g] & wen_r[g];
`endif
  end

  // Stage registers: payload shifts whenever not stalled; valid bits and occupancy also clear on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      wen_r <= '0;
      occ   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat[k] <= '0;
        tg[k]  <= '0;
        ct[k]  <= '0;
      end
    end else begin
      if (!stall) begin
        dat[0]   <= in_data;
        tg[0]    <= in_tag;
        ct[0]    <= in_ctrl;
        wen_r[0] <= in_wen;
        for (int k = 1; k < DEPTH; k++) begin
          dat[k]   <= dat[k-1];
          tg[k]    <= tg[k-1];
          ct[k]    <= ct[k-1];
          wen_r[k] <= wen_r[k-1];
        end
      end
      if (flush) begin
        vld <= '0;
        occ <= '0;
      end else if (!stall) begin
        vld[0] <= in_valid;
        for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
        occ <= occ + 4'(in_valid) - 4'(vld[DEPTH-1]);
      end
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (live[k] && tg[k] == src_a) begin
        hit_a = 1'b1;
        fwd_a = dat[k];
      end
      if (live[k] && tg[k] == src_b) begin
        hit_b = 1'b1;
        fwd_b = dat[k];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_tag   = tg[DEPTH-1];
  assign out_wen   = live[DEPTH-1];
  assign out_ctrl  = vld[DEPTH-1] ? ct[DEPTH-1] : '0;
endmodule

// File: tb/tb_pipe_tag_chain.sv
// tb_pipe_tag_chain: scoreboard bench for pipe_tag_chain at DEPTH=3
module tb_pipe_tag_chain;
`ifdef PIPE_ZERO_TAG_EN
  localparam bit ZT = 1'b1;
`else
  localparam bit ZT = 1'b0;
`endif
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  t;
    logic        w;
    logic [1:0]  c;
  } ent_t;

  logic clk = 0, rst = 1, in_valid = 0, in_wen = 0, stall = 0, flush = 0;
  logic [15:0] in_data = 0;
  logic [3:0] in_tag = 0, src_a = 0, src_b = 0;
  logic [1:0] in_ctrl = 0;
  logic in_ready, hit_a, hit_b, out_valid, out_wen;
  logic [15:0] fwd_a, fwd_b, out_data;
  logic [3:0] out_tag, occ;
  logic [1:0] out_ctrl;
  int vectors = 0, miscompares = 0;
  bit shifted = 0;
  ent_t sb[$];
  ent_t e;

  pipe_tag_chain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .in_wen(in_wen), .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_wen(out_wen),
    .out_ctrl(out_ctrl), .occ(occ)
  );

  always #5 clk = ~clk;

  // Output monitor: every entry leaving the chain must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && out_valid && shifted) begin
      shifted = 0;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra: got tag %0d data %h, none expected", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_tag, out_wen, out_ctrl} !== e) begin
          miscompares++;
          $display("FAIL sb_out: got d=%h t=%0d w=%b c=%0d want d=%h t=%0d w=%b c=%0d",
                   out_data, out_tag, out_wen, out_ctrl, e.d, e.t, e.w, e.c);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] t, input logic w,
                     input logic [1:0] c, input logic st, input logic fl);
    in_valid = v; in_data = d; in_tag = t; in_wen = w; in_ctrl = c; stall = st; flush = fl;
    @(posedge clk);
    shifted = !st && !fl;
    if (fl) sb.delete();
    else if (v && !st) sb.push_back('{d: d, t: t, w: w && !(ZT && t == 4'd0), c: c});
    #1;
  endtask

  task automatic bub(input int n);
    repeat (n) cyc(0, 16'h0, 4'd0, 0, 2'd0, 0, 0);
  endtask

  task automatic test_reset;
    stall = 1;
    #1;
    vectors++;
    if ({out_valid, out_data, out_tag, out_wen, out_ctrl, occ, hit_a, hit_b, fwd_a, fwd_b, in_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got v=%b d=%h t=%0d w=%b c=%0d occ=%0d ha=%b hb=%b rdy=%b want all 0",
               out_valid, out_data, out_tag, out_wen, out_ctrl, occ, hit_a, hit_b, in_ready);
    end
    stall = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic;
    int eo[5] = '{1, 2, 2, 1, 0};
    logic ev[5] = '{0, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(i < 2, i == 0 ? 16'h1111 : 16'h2222, i == 0 ? 4'd3 : 4'd5, 1, 2'd1, 0, 0);
      vectors++;
      if (occ !== 4'(eo[i]) || out_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL basic_cyc%0d: got occ=%0d v=%b want occ=%0d v=%b", i, occ, out_valid, eo[i], ev[i]);
      end
    end
  endtask

  task automatic test_youngest;
    logic eh[3] = '{1, 1, 0};
    logic [15:0] ef[3] = '{16'hBBBB, 16'hBBBB, 16'h0};
    src_a = 4'd7;
    cyc(1, 16'hAAAA, 4'd7, 1, 2'd0, 0, 0);
    cyc(1, 16'hBBBB, 4'd7, 1, 2'd0, 0, 0);
    vectors++;
    if (hit_a !== 1'b1 || fwd_a !== 16'hBBBB) begin
      miscompares++;
      $display("FAIL young_entry: got hit=%b fwd=%h want 1 bbbb", hit_a, fwd_a);
    end
    for (int i = 0; i < 3; i++) begin
      bub(1);
      vectors++;
      if (hit_a !== eh[i] || fwd_a !== ef[i]) begin
        miscompares++;
        $display("FAIL young_drain%0d: got hit=%b fwd=%h want %b %h", i, hit_a, fwd_a, eh[i], ef[i]);
      end
    end
  endtask

  task automatic test_stall;
    int eo[3] = '{2, 1, 0};
    src_a = 4'd1; src_b = 4'd2;
    cyc(1, 16'h0C0C, 4'd1, 1, 2'd2, 0, 0);
    cyc(1, 16'h0D0D, 4'd2, 1, 2'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'hEEEE, 4'd3, 1, 2'd1, 1, 0);
      vectors++;
      if ({in_ready, occ, out_valid, hit_a, fwd_a, hit_b, fwd_b} !==
          {1'b0, 4'd2, 1'b0, 1'b1, 16'h0C0C, 1'b1, 16'h0D0D}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got rdy=%b occ=%0d v=%b ha=%b fa=%h hb=%b fb=%h want 0 2 0 1 0c0c 1 0d0d",
                 i, in_ready, occ, out_valid, hit_a, fwd_a, hit_b, fwd_b);
      end
    end
    for (int i = 0; i < 3; i++) begin
      bub(1);
      vectors++;
      if (occ !== 4'(eo[i])) begin
        miscompares++;
        $display("FAIL stall_release%0d: got occ=%0d want %0d", i, occ, eo[i]);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_lost: got %0d entries still pending want 0", sb.size());
    end
  endtask

  task automatic test_flush;
    src_a = 4'd4; src_b = 4'd6;
    cyc(1, 16'h4444, 4'd4, 1, 2'd1, 0, 0);
    cyc(1, 16'h5555, 4'd5, 1, 2'd2, 0, 0);
    cyc(1, 16'h6666, 4'd6, 1, 2'd3, 0, 0);
    vectors++;
    if (occ !== 4'd3 || hit_a !== 1'b1 || hit_b !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full: got occ=%0d ha=%b hb=%b want 3 1 1", occ, hit_a, hit_b);
    end
    cyc(1, 16'hFFFF, 4'd8, 1, 2'd3, 1, 1);
    vectors++;
    if ({occ, out_valid, hit_a, hit_b, out_wen, out_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL flush_clear: got occ=%0d v=%b ha=%b hb=%b w=%b c=%0d want all 0",
               occ, out_valid, hit_a, hit_b, out_wen, out_ctrl);
    end
    bub(3);
    vectors++;
    if (occ !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_after: got occ=%0d want 0", occ);
    end
  endtask

  task automatic test_nowen;
    src_b = 4'd9;
    cyc(1, 16'h9999, 4'd9, 0, 2'd3, 0, 0);
    vectors++;
    if (hit_b !== 1'b0) begin
      miscompares++;
      $display("FAIL nowen_s0: got hit_b=%b want 0", hit_b);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h5555, 4'd9, 1, 2'd3, 0, 0);
      vectors++;
      if (hit_b !== 1'b0) begin
        miscompares++;
        $display("FAIL nowen_hit%0d: got hit_b=%b want 0", i, hit_b);
      end
      if (i >= 2) begin
        vectors++;
        if ({out_valid, out_wen, out_ctrl} !== 4'b0) begin
          miscompares++;
          $display("FAIL bubble_gate%0d: got v=%b w=%b c=%0d want 0 0 0", i, out_valid, out_wen, out_ctrl);
        end
      end
    end
  endtask

  task automatic test_zero_tag;
    src_a = 4'd0;
    cyc(1, 16'h1234, 4'd0, 1, 2'd1, 0, 0);
    vectors++;
    if (hit_a !== !ZT || fwd_a !== (ZT ? 16'h0 : 16'h1234)) begin
      miscompares++;
      $display("FAIL zero_tag: got hit=%b fwd=%h want %b %h", hit_a, fwd_a, !ZT, ZT ? 16'h0 : 16'h1234);
    end
    bub(3);
  endtask

  task automatic test_reset_mid;
    logic ev[3] = '{0, 1, 0};
    src_a = 4'd2;
    cyc(1, 16'h2020, 4'd2, 1, 2'd1, 0, 0);
    cyc(1, 16'h3030, 4'd3, 1, 2'd1, 0, 0);
    #2 rst = 1;
    #1;
    sb.delete();
    shifted = 0;
    vectors++;
    if ({out_valid, occ, hit_a, fwd_a} !== '0) begin
      miscompares++;
      $display("FAIL midreset: got v=%b occ=%0d ha=%b fa=%h want all 0", out_valid, occ, hit_a, fwd_a);
    end
    @(negedge clk);
    rst = 0;
    cyc(1, 16'h7777, 4'd2, 1, 2'd2, 0, 0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_lat0: got v=%b want 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      bub(1);
      vectors++;
      if (out_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL midreset_lat%0d: got v=%b want %b", i + 1, out_valid, ev[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_youngest;
    test_stall;
    test_flush;
    test_nowen;
    test_zero_tag;
    test_reset_mid;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
